// File: rtl/rv32_ahb_arbiter_pkg.sv
// rtl/rv32_ahb_arbiter_pkg.sv - shared AHB-Lite constants, master indices and per-master arbitration state
package rv32_ahb_arbiter_pkg;

    localparam int ARB_XLEN = 32;

    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;

    localparam logic [2:0] AHB_SIZE_BYTE = 3'b000;
    localparam logic [2:0] AHB_SIZE_HALF = 3'b001;
    localparam logic [2:0] AHB_SIZE_WORD = 3'b010;

    localparam logic AHB_OKAY  = 1'b0;
    localparam logic AHB_ERROR = 1'b1;

    localparam logic [1:0] M_IFETCH = 2'd0;
    localparam logic [1:0] M_LSU    = 2'd1;
    localparam logic [1:0] M_DMA    = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rv32_ahb_arbiter_if.sv
// rtl/rv32_ahb_arbiter_if.sv - master-side request/response bundle plus the shared slave-side AHB-Lite bus
interface rv32_ahb_arbiter_if #(
    parameter int NUM_M = 3,
    parameter int XLEN  = rv32_ahb_arbiter_pkg::ARB_XLEN
);
    logic [NUM_M-1:0][XLEN-1:0] m_haddr;
    logic [NUM_M-1:0][1:0]      m_htrans;
    logic [NUM_M-1:0]           m_hwrite;
    logic [NUM_M-1:0][2:0]      m_hsize;
    logic [NUM_M-1:0][XLEN-1:0] m_hwdata;
    logic [XLEN-1:0]            m_hrdata;
    logic [NUM_M-1:0]           m_hready;
    logic [NUM_M-1:0]           m_hresp;

    logic [XLEN-1:0]            HADDR;
    logic [1:0]                 HTRANS;
    logic                       HWRITE;
    logic [2:0]                 HSIZE;
    logic [XLEN-1:0]            HWDATA;
    logic [XLEN-1:0]            HRDATA;
    logic                       HREADY;
    logic                       HRESP;
    logic [1:0]                 HMASTER;

    // Arbiter side: takes master requests and the slave response, drives both outward
    modport slave (
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
        output m_hrdata, m_hready, m_hresp,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER,
        input  HRDATA, HREADY, HRESP
    );

    // Environment side: the masters and the downstream slave
    modport master (
        output m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
        input  m_hrdata, m_hready, m_hresp,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/rv32_ahb_arb_stage.sv
// rtl/rv32_ahb_arb_stage.sv - per-master IDLE/PEND/DATA tracker with the buffered address phase
module rv32_ahb_arb_stage
    import rv32_ahb_arbiter_pkg::*;
#(
    parameter int XLEN = ARB_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      htrans,
    input  logic [XLEN-1:0] haddr,
    input  logic            hwrite,
    input  logic [2:0]      hsize,
    input  logic            grant,
    input  logic            hready,
    input  logic            hresp,
    output logic            cand,
    output logic            m_hready,
    output logic            m_hresp,
    output logic [XLEN-1:0] sel_addr,
    output logic            sel_write,
    output logic [2:0]      sel_size
);
    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_PEND = ARB_PEND;
    localparam logic [1:0] S_DATA = ARB_DATA;

    logic [1:0]      state_q;
    logic [XLEN-1:0] buf_addr_q;
    logic            buf_write_q;
    logic [2:0]      buf_size_q;
    logic            req;
    logic            accept;
    logic            pend;

    assign req      = (htrans == AHB_NONSEQ);
    assign pend     = (state_q == S_PEND);
    // In the data phase the master sees the slave's wait states and response directly
    assign m_hready = (state_q == S_DATA) ? hready : (state_q == S_IDLE);
    assign m_hresp  = (state_q == S_DATA) && hresp;
    assign accept   = req && m_hready;
    assign cand     = pend || accept;

    // A pending master replays its captured phase, otherwise the live inputs go through
    assign sel_addr  = pend ? buf_addr_q  : haddr;
    assign sel_write = pend ? buf_write_q : hwrite;
    assign sel_size  = pend ? buf_size_q  : hsize;

    // Advance the master's state; capture the request whenever it is accepted but not issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_addr_q  <= '0;
            buf_write_q <= 1'b0;
            buf_size_q  <= '0;
        end else begin
            case (state_q)
                S_PEND: begin
                    if (grant && hready) begin
                        state_q <= S_DATA;
                    end
                end
                S_IDLE, S_DATA: begin
                    if (accept) begin
                        if (grant && hready) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q     <= S_PEND;
                            buf_addr_q  <= haddr;
                            buf_write_q <= hwrite;
                            buf_size_q  <= hsize;
                        end
                    end else if ((state_q == S_DATA) && hready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rv32_ahb_arbiter.sv
// rtl/rv32_ahb_arbiter.sv - multi-master AHB-Lite arbiter; RV32_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module rv32_ahb_arbiter
    import rv32_ahb_arbiter_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int XLEN  = ARB_XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_ahb_arbiter_if.slave    bus
);
    logic [NUM_M-1:0]           cand;
    logic [NUM_M-1:0]           grant;
    logic [NUM_M-1:0]           hready_v;
    logic [NUM_M-1:0]           hresp_v;
    logic [NUM_M-1:0][XLEN-1:0] sel_addr;
    logic [NUM_M-1:0]           sel_write;
    logic [NUM_M-1:0][2:0]      sel_size;

    logic [1:0]      winner;
    logic            any_cand;

    logic [XLEN-1:0] nxt_addr;
    logic [1:0]      nxt_trans;
    logic            nxt_write;
    logic [2:0]      nxt_size;
    logic [1:0]      nxt_master;

    logic [XLEN-1:0] ap_addr_q;
    logic [1:0]      ap_trans_q;
    logic            ap_write_q;
    logic [2:0]      ap_size_q;
    logic [1:0]      ap_master_q;

    logic            owner_vld_q;
    logic [1:0]      owner_q;

    for (genvar i = 0; i < NUM_M; i++) begin : g_stage
        rv32_ahb_arb_stage #(.XLEN(XLEN)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .htrans    (bus.m_htrans[i]),
            .haddr     (bus.m_haddr[i]),
            .hwrite    (bus.m_hwrite[i]),
            .hsize     (bus.m_hsize[i]),
            .grant     (grant[i]),
            .hready    (bus.HREADY),
            .hresp     (bus.HRESP),
            .cand      (cand[i]),
            .m_hready  (hready_v[i]),
            .m_hresp   (hresp_v[i]),
            .sel_addr  (sel_addr[i]),
            .sel_write (sel_write[i]),
            .sel_size  (sel_size[i])
        );
        assign grant[i] = bus.HREADY && any_cand && (winner == 2'(i));
    end

    assign any_cand = |cand;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;

    // Round-robin pick: the first candidate at or after the pointer wins
    always_comb begin
        int         s;
        logic [1:0] idx;
        winner = '0;
        s      = 0;
        idx    = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_M) begin
                s = s - NUM_M;
            end
            idx = 2'(s);
            if (cand[idx]) begin
                winner = idx;
            end
        end
    end

    // Move the pointer past each winner whose address phase the slave takes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (bus.HREADY && any_cand) begin
            ptr_q <= (int'(winner) >= NUM_M - 1) ? 2'd0 : winner + 2'd1;
        end
    end
`else
    // Fixed priority: load/store first, then instruction fetch, then the rest by index
    always_comb begin
        winner = '0;
        for (int i = NUM_M - 1; i >= 2; i--) begin
            if (cand[2'(i)]) begin
                winner = 2'(i);
            end
        end
        if (cand[M_IFETCH]) begin
            winner = M_IFETCH;
        end
        if (cand[M_LSU]) begin
            winner = M_LSU;
        end
    end
`endif

    // Address phase the winner would put on the bus this cycle; idle pattern when nobody asks
    always_comb begin
        nxt_addr   = '0;
        nxt_trans  = AHB_IDLE;
        nxt_write  = 1'b0;
        nxt_size   = AHB_SIZE_WORD;
        nxt_master = ap_master_q;
        if (any_cand) begin
            nxt_addr   = sel_addr[winner];
            nxt_trans  = AHB_NONSEQ;
            nxt_write  = sel_write[winner];
            nxt_size   = sel_size[winner];
            nxt_master = winner;
        end
    end

    // Remember the last sampled address phase so it stays frozen through wait states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap_addr_q   <= '0;
            ap_trans_q  <= AHB_IDLE;
            ap_write_q  <= 1'b0;
            ap_size_q   <= AHB_SIZE_WORD;
            ap_master_q <= '0;
        end else if (bus.HREADY) begin
            ap_addr_q   <= nxt_addr;
            ap_trans_q  <= nxt_trans;
            ap_write_q  <= nxt_write;
            ap_size_q   <= nxt_size;
            ap_master_q <= nxt_master;
        end
    end

    // Data-phase owner follows the address phase the slave just accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
        end else if (bus.HREADY) begin
            owner_vld_q <= any_cand;
            owner_q     <= winner;
        end
    end

    assign bus.HADDR   = bus.HREADY ? nxt_addr   : ap_addr_q;
    assign bus.HTRANS  = bus.HREADY ? nxt_trans  : ap_trans_q;
    assign bus.HWRITE  = bus.HREADY ? nxt_write  : ap_write_q;
    assign bus.HSIZE   = bus.HREADY ? nxt_size   : ap_size_q;
    assign bus.HMASTER = bus.HREADY ? nxt_master : ap_master_q;

    assign bus.HWDATA   = owner_vld_q ? bus.m_hwdata[owner_q] : '0;
    assign bus.m_hrdata = bus.HRDATA;
    assign bus.m_hready = hready_v;
    assign bus.m_hresp  = hresp_v;

endmodule

// File: tb/tb_rv32_ahb_arbiter.sv
// tb/tb_rv32_ahb_arbiter.sv - directed self-checking bench for rv32_ahb_arbiter
module tb_rv32_ahb_arbiter;
    import rv32_ahb_arbiter_pkg::*;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    rv32_ahb_arbiter_if #(.NUM_M(3), .XLEN(32)) bus ();

    rv32_ahb_arbiter #(.NUM_M(3), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            bus.m_htrans[2'(i)] = AHB_IDLE;
            bus.m_haddr[2'(i)]  = '0;
            bus.m_hwrite[2'(i)] = 1'b0;
            bus.m_hsize[2'(i)]  = AHB_SIZE_WORD;
            bus.m_hwdata[2'(i)] = '0;
        end
    endtask

    task automatic req(input logic [1:0] m, input logic [31:0] a, input logic w);
        bus.m_htrans[m] = AHB_NONSEQ;
        bus.m_haddr[m]  = a;
        bus.m_hwrite[m] = w;
        bus.m_hsize[m]  = AHB_SIZE_WORD;
    endtask

    initial begin
        int exp_m;
        idle_all();
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h1234_5678;

        // reset state
        sample();
        chk("rst_htrans", bus.HTRANS, AHB_IDLE);
        chk("rst_hready", bus.m_hready, 3'b111);
        chk("rst_hresp", bus.m_hresp, 3'b000);
        chk("rst_hrdata", bus.m_hrdata, 32'h1234_5678);
        chk("rst_hmaster", bus.HMASTER, 2'd0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        tick();
        rst = 1'b0;

        // M0 and M1 collide: one issues now, the other is replayed next cycle
        req(2'd0, 32'h000, 1'b0);
        req(2'd1, 32'h100, 1'b0);
        sample();
        chk("col_haddr", bus.HADDR, RR ? 32'h000 : 32'h100);
        chk("col_hmaster", bus.HMASTER, RR ? 2'd0 : 2'd1);
        chk("col_htrans", bus.HTRANS, AHB_NONSEQ);
        tick();
        idle_all();
        sample();
        chk("replay_haddr", bus.HADDR, RR ? 32'h100 : 32'h000);
        chk("replay_hmaster", bus.HMASTER, RR ? 2'd1 : 2'd0);
        chk("replay_hready", bus.m_hready, RR ? 3'b101 : 3'b110);
        chk("replay_htrans", bus.HTRANS, AHB_NONSEQ);
        tick();
        sample();
        chk("idle_htrans", bus.HTRANS, AHB_IDLE);
        chk("idle_haddr", bus.HADDR, 32'h0);
        chk("idle_hmaster_hold", bus.HMASTER, RR ? 2'd1 : 2'd0);
        chk("idle_hsize", bus.HSIZE, AHB_SIZE_WORD);
        tick();
        sample();
        chk("idle_hready", bus.m_hready, 3'b111);

        // M1 write with two wait states; M0 arrives during the stall
        tick();
        req(2'd1, 32'h200, 1'b1);
        sample();
        chk("wr_haddr", bus.HADDR, 32'h200);
        chk("wr_hwrite", bus.HWRITE, 1'b1);
        chk("wr_hmaster", bus.HMASTER, 2'd1);
        tick();
        idle_all();
        bus.m_hwdata[1] = 32'hDEAD_BEEF;
        bus.m_hwdata[0] = 32'hA5A5_A5A5;
        req(2'd0, 32'h300, 1'b0);
        bus.HREADY = 1'b0;
        sample();
        chk("ws1_haddr", bus.HADDR, 32'h200);
        chk("ws1_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("ws1_hready", bus.m_hready, 3'b101);
        tick();
        bus.m_htrans[0] = AHB_IDLE;
        sample();
        chk("ws2_haddr", bus.HADDR, 32'h200);
        chk("ws2_hwrite", bus.HWRITE, 1'b1);
        chk("ws2_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("ws2_hready", bus.m_hready, 3'b100);
        tick();
        bus.HREADY = 1'b1;
        sample();
        chk("wsend_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("wsend_hready", bus.m_hready, 3'b110);
        chk("wsend_haddr", bus.HADDR, 32'h300);
        chk("wsend_hmaster", bus.HMASTER, 2'd0);
        chk("wsend_hwrite", bus.HWRITE, 1'b0);
        tick();
        sample();
        chk("own0_hwdata", bus.HWDATA, 32'hA5A5_A5A5);
        chk("own0_htrans", bus.HTRANS, AHB_IDLE);
        tick();
        sample();
        chk("noown_hwdata", bus.HWDATA, 32'h0);

        // ERROR on an M2 read reaches only M2, for both cycles
        tick();
        idle_all();
        req(2'd2, 32'hFFFF_0000, 1'b0);
        sample();
        chk("err_haddr", bus.HADDR, 32'hFFFF_0000);
        chk("err_hmaster", bus.HMASTER, 2'd2);
        tick();
        idle_all();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        sample();
        chk("err1_hresp", bus.m_hresp, 3'b100);
        chk("err1_hready", bus.m_hready, 3'b011);
        tick();
        bus.HREADY = 1'b1;
        sample();
        chk("err2_hresp", bus.m_hresp, 3'b100);
        tick();
        bus.HRESP = 1'b0;
        sample();
        chk("err_done_hresp", bus.m_hresp, 3'b000);

        // M1 back-to-back loads: the second issues as the first completes
        tick();
        req(2'd1, 32'h10, 1'b0);
        sample();
        chk("b2b_haddr0", bus.HADDR, 32'h10);
        tick();
        req(2'd1, 32'h14, 1'b0);
        bus.HRDATA = 32'hCAFE_F00D;
        sample();
        chk("b2b_haddr1", bus.HADDR, 32'h14);
        chk("b2b_htrans", bus.HTRANS, AHB_NONSEQ);
        chk("b2b_hready", bus.m_hready, 3'b111);
        chk("b2b_hrdata", bus.m_hrdata, 32'hCAFE_F00D);
        tick();
        idle_all();
        sample();
        chk("b2b_end_htrans", bus.HTRANS, AHB_IDLE);
        chk("b2b_end_hready", bus.m_hready, 3'b111);

        // Reset with one master pending and another in its data phase
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req(2'd0, 32'h40, 1'b0);
        req(2'd1, 32'h80, 1'b0);
        sample();
        tick();
        idle_all();
        bus.HREADY = 1'b0;
        sample();
        chk("prerst_hready", bus.m_hready, 3'b100);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_htrans", bus.HTRANS, AHB_IDLE);
        chk("async_rst_hready", bus.m_hready, 3'b111);
        tick();
        sample();
        chk("rst_cycle_htrans", bus.HTRANS, AHB_IDLE);
        chk("rst_cycle_hready", bus.m_hready, 3'b111);
        tick();
        rst = 1'b0;
        bus.HREADY = 1'b1;
        sample();
        chk("postrst_htrans", bus.HTRANS, AHB_IDLE);
        chk("postrst_hready", bus.m_hready, 3'b111);
        tick();
        sample();
        chk("noreplay_htrans", bus.HTRANS, AHB_IDLE);

        // All three masters request continuously
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
            end
            req(2'd0, 32'hA0, 1'b0);
            req(2'd1, 32'hB0, 1'b0);
            req(2'd2, 32'hC0, 1'b0);
            exp_m = RR ? ((k == 3) ? 0 : k) : 1;
            sample();
            chk($sformatf("cont%0d_hmaster", k), bus.HMASTER, 32'(exp_m));
            chk($sformatf("cont%0d_haddr", k), bus.HADDR, 32'hA0 + 32'(16 * exp_m));
        end
        tick();
        rst = 1'b1;
        idle_all();
        tick();
        rst = 1'b0;
        sample();
        chk("final_htrans", bus.HTRANS, AHB_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
